// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Words arrive on a valid/ready stream into a small FIFO. A five-state FSM
// (IDLE, START, DATA, PARITY, STOP) serialises them LSB-first. Back-to-back
// frames are sent with no idle gap between the last stop bit and the next
// start bit. The serial line is registered, so it only moves on bit
// boundaries.
module uart_tx_frame #(
  parameter int CLK_FREQ    = 50000000,
  parameter int UART_BPS    = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // Bit period in system clocks and derived counter widths.
  localparam int BIT_P  = CLK_FREQ / UART_BPS;
  localparam int BAUD_W = (BIT_P > 1) ? $clog2(BIT_P) : 1;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  // Counts data bits (max 9) and stop bits (max 2).
  localparam int BIT_W  = 4;

  // Elaboration-time rejection of unsupported configurations.
  if (BIT_P < 4) begin : g_bad_baud
    $error("uart_tx_frame: CLK_FREQ/UART_BPS must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_frame: FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity bit for a word: even mode sends the XOR of the data bits,
  // odd mode sends its inverse.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    logic p;
    p = ^word;
    return (PARITY_MODE == 1) ? ~p : p;
  endfunction

  // ---------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;

  assign s_ready    = (count != CNT_W'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign fifo_empty = (count == '0);
  assign fifo_head  = mem[rd_ptr];
  assign fifo_count = count;

  // FIFO storage: data only, never reset.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  state_t               state;
  state_t               state_nxt;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 baud_tick;
  logic                 last_data;
  logic                 last_stop;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 parity_bit;
  logic                 parity_nxt;
  logic                 tx_nxt;

  assign baud_tick = (baud_cnt == BAUD_W'(BIT_P - 1));
  assign last_data = (bit_cnt == BIT_W'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; pops happen only on entry to START.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = START;
          pop       = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (baud_tick && last_data) begin
          state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_tick && last_stop) begin
          if (!fifo_empty) begin
            state_nxt = START;
            pop       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs: busy follows the current state, the line level is prepared
  // from the next state so the registered line moves on the same edge.
  always_comb begin
    tx_busy = (state != IDLE);
    tx_nxt  = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = parity_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  // Baud and bit counters: the baud counter restarts at every bit boundary
  // and is held at zero while idle; the bit counter restarts on each state change.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == IDLE || state_nxt == IDLE || baud_tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
      if (state_nxt != state) begin
        bit_cnt <= '0;
      end else if (baud_tick && (state == DATA || state == STOP)) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // Shift register and parity: load on pop, shift right at each data-bit boundary.
  always_comb begin
    shift_nxt  = shift_reg;
    parity_nxt = parity_bit;
    if (pop) begin
      shift_nxt  = fifo_head;
      parity_nxt = parity_of(fifo_head);
    end else if (state == DATA && baud_tick) begin
      shift_nxt = shift_reg >> 1;
    end
  end

  // Datapath registers, not reset.
  always_ff @(posedge sys_clk) begin
    shift_reg  <= shift_nxt;
    parity_bit <= parity_nxt;
  end

  // Registered serial line; reset drives it high immediately.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx <= 1'b1;
    end else begin
      tx <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five configurations (8N1, 8E1, 8O1, 8N2, 7N1)
// at P = 10, driven with fixed and random words and compared cycle by cycle
// against a frame-level reference waveform and FIFO occupancy model.
module tb_uart_tx_frame;
  localparam int P = 10;
  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] s_dat  [NI];
  logic       s_val  [NI];
  logic       s_rdy  [NI];
  logic       tx_w   [NI];
  logic       busy_w [NI];
  logic [2:0] cnt_w  [NI];

  int tests = 0;
  int fails = 0;

  logic [7:0] wq[$];
  int         acc_cyc[$];
  bit         exp_wave[$];
  int         max_cnt;

  uart_tx_frame #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .sys_clk(clk), .sys_rst(rst), .s_data(s_dat[0]), .s_valid(s_val[0]),
    .s_ready(s_rdy[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .fifo_count(cnt_w[0]));

  uart_tx_frame #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(8),
                  .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .sys_clk(clk), .sys_rst(rst), .s_data(s_dat[1]), .s_valid(s_val[1]),
    .s_ready(s_rdy[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .fifo_count(cnt_w[1]));

  uart_tx_frame #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(8),
                  .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .sys_clk(clk), .sys_rst(rst), .s_data(s_dat[2]), .s_valid(s_val[2]),
    .s_ready(s_rdy[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .fifo_count(cnt_w[2]));

  uart_tx_frame #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8n2 (
    .sys_clk(clk), .sys_rst(rst), .s_data(s_dat[3]), .s_valid(s_val[3]),
    .s_ready(s_rdy[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .fifo_count(cnt_w[3]));

  uart_tx_frame #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(7),
                  .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7n1 (
    .sys_clk(clk), .sys_rst(rst), .s_data(s_dat[4][6:0]), .s_valid(s_val[4]),
    .s_ready(s_rdy[4]), .tx(tx_w[4]), .tx_busy(busy_w[4]), .fifo_count(cnt_w[4]));

  // Reference waveform: one entry per clock, built from the frame rules
  // (start 0, data LSB first, optional parity, stop 1s), each bit P clocks.
  function automatic void build_wave(input int dbits, input int pmode, input int sbits);
    exp_wave.delete();
    foreach (wq[i]) begin
      int ones;
      bit bits[$];
      ones = 0;
      bits.delete();
      bits.push_back(1'b0);
      for (int j = 0; j < dbits; j++) begin
        bits.push_back(wq[i][j]);
        ones += int'(wq[i][j]);
      end
      if (pmode == 2) bits.push_back(ones % 2 == 1);
      else if (pmode == 1) bits.push_back(ones % 2 == 0);
      for (int s = 0; s < sbits; s++) bits.push_back(1'b1);
      foreach (bits[b]) for (int r = 0; r < P; r++) exp_wave.push_back(bits[b]);
    end
  endfunction

  function automatic void fill_random(input int n, input logic [7:0] mask);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(8'($urandom_range(0, 255)) & mask);
  endfunction

  // Push every word of wq into instance idx and check the serial output,
  // busy flag, FIFO count and ready against the reference every cycle.
  task automatic run_stream(input string name, input int idx, input int dbits,
                            input int pmode, input int sbits);
    int flen;
    int nw;
    int total;
    flen = (1 + dbits + ((pmode != 0) ? 1 : 0) + sbits) * P;
    nw = wq.size();
    build_wave(dbits, pmode, sbits);
    total = exp_wave.size();
    acc_cyc.delete();
    max_cnt = 0;
    fork
      begin : pusher
        foreach (wq[i]) begin
          bit rdy;
          bit done;
          int g;
          done = 1'b0;
          g = 0;
          s_dat[idx] = wq[i];
          s_val[idx] = 1'b1;
          while (!done && g < 3000) begin
            rdy = s_rdy[idx];
            @(posedge clk);
            #1;
            if (rdy) begin
              done = 1'b1;
              acc_cyc.push_back(cyc);
            end
            g++;
          end
          if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s push timeout word %0d: accepted 0, required 1", name, i);
            break;
          end
        end
        s_val[idx] = 1'b0;
      end
      begin : monitor
        int guard;
        int acc0;
        int c;
        int na;
        int np;
        int exp_cnt;
        guard = 0;
        while (acc_cyc.size() == 0 && guard < 50) begin
          @(posedge clk);
          #2;
          guard++;
        end
        tests++;
        if (acc_cyc.size() == 0) begin
          fails++;
          $display("FAIL %s first accept: got none, required within 50 cycles", name);
        end else begin
          acc0 = acc_cyc[0];
          if (tx_w[idx] !== 1'b1 || busy_w[idx] !== 1'b0) begin
            fails++;
            $display("FAIL %s pre-start: tx=%b busy=%b, required tx=1 busy=0",
                     name, tx_w[idx], busy_w[idx]);
          end
          for (int k = 0; k < total; k++) begin
            @(posedge clk);
            #2;
            c = cyc;
            na = 0;
            np = 0;
            foreach (acc_cyc[a]) if (acc_cyc[a] <= c) na++;
            for (int f = 0; f < nw; f++) if (acc0 + 1 + f * flen <= c) np++;
            exp_cnt = na - np;
            if (int'(cnt_w[idx]) > max_cnt) max_cnt = int'(cnt_w[idx]);
            tests++;
            if (tx_w[idx] !== exp_wave[k]) begin
              fails++;
              $display("FAIL %s tx cycle %0d: got %b, required %b", name, k, tx_w[idx], exp_wave[k]);
            end
            tests++;
            if (busy_w[idx] !== 1'b1) begin
              fails++;
              $display("FAIL %s busy cycle %0d: got %b, required 1", name, k, busy_w[idx]);
            end
            tests++;
            if (cnt_w[idx] !== 3'(exp_cnt)) begin
              fails++;
              $display("FAIL %s fifo_count cycle %0d: got %0d, required %0d", name, k, cnt_w[idx], exp_cnt);
            end
            tests++;
            if (s_rdy[idx] !== (exp_cnt < 4)) begin
              fails++;
              $display("FAIL %s s_ready cycle %0d: got %b, required %b", name, k, s_rdy[idx], exp_cnt < 4);
            end
          end
          @(posedge clk);
          #2;
          tests++;
          if (tx_w[idx] !== 1'b1 || busy_w[idx] !== 1'b0 || cnt_w[idx] !== 3'd0) begin
            fails++;
            $display("FAIL %s end idle: tx=%b busy=%b count=%0d, required 1 0 0",
                     name, tx_w[idx], busy_w[idx], cnt_w[idx]);
          end
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      tests++;
      if (tx_w[i] !== 1'b1) begin
        fails++; $display("FAIL reset tx inst%0d: got %b, required 1", i, tx_w[i]);
      end
      tests++;
      if (busy_w[i] !== 1'b0) begin
        fails++; $display("FAIL reset busy inst%0d: got %b, required 0", i, busy_w[i]);
      end
      tests++;
      if (s_rdy[i] !== 1'b1) begin
        fails++; $display("FAIL reset s_ready inst%0d: got %b, required 1", i, s_rdy[i]);
      end
      tests++;
      if (cnt_w[i] !== 3'd0) begin
        fails++; $display("FAIL reset fifo_count inst%0d: got %0d, required 0", i, cnt_w[i]);
      end
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      fails++; $display("FAIL post-reset idle: tx=%b busy=%b, required 1 0", tx_w[0], busy_w[0]);
    end
  endtask

  task automatic test_8n1();
    wq.delete();
    wq.push_back(8'h55);
    run_stream("8n1_0x55", 0, 8, 0, 1);
    fill_random(3, 8'hFF);
    run_stream("8n1_rand", 0, 8, 0, 1);
  endtask

  task automatic test_parity();
    wq.delete();
    wq.push_back(8'h07);
    run_stream("even_0x07", 1, 8, 2, 1);
    wq.delete();
    wq.push_back(8'h07);
    run_stream("odd_0x07", 2, 8, 1, 1);
    fill_random(4, 8'hFF);
    run_stream("even_rand", 1, 8, 2, 1);
    fill_random(4, 8'hFF);
    run_stream("odd_rand", 2, 8, 1, 1);
  endtask

  task automatic test_back_to_back();
    wq.delete();
    wq.push_back(8'hA5);
    wq.push_back(8'h3C);
    run_stream("two_stop_a5_3c", 3, 8, 0, 2);
    fill_random(3, 8'hFF);
    run_stream("two_stop_rand", 3, 8, 0, 2);
  endtask

  task automatic test_fifo_full();
    fill_random(6, 8'hFF);
    run_stream("fifo_full", 0, 8, 0, 1);
    tests++;
    if (max_cnt !== 4) begin
      fails++; $display("FAIL fifo_full peak count: got %0d, required 4", max_cnt);
    end
    tests++;
    if (acc_cyc.size() != 6) begin
      fails++; $display("FAIL fifo_full accepts: got %0d, required 6", acc_cyc.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        tests++;
        if (acc_cyc[i] != acc_cyc[0] + i) begin
          fails++;
          $display("FAIL fifo_full accept word %0d: got cycle %0d, required %0d",
                   i, acc_cyc[i], acc_cyc[0] + i);
        end
      end
      tests++;
      if (acc_cyc[5] != acc_cyc[0] + 100 + 2) begin
        fails++;
        $display("FAIL fifo_full accept word 5: got cycle %0d, required %0d",
                 acc_cyc[5], acc_cyc[0] + 102);
      end
    end
  endtask

  task automatic test_seven_bit();
    wq.delete();
    wq.push_back(8'h7F);
    run_stream("seven_0x7f", 4, 7, 0, 1);
    fill_random(3, 8'h7F);
    run_stream("seven_rand", 4, 7, 0, 1);
  endtask

  task automatic test_reset_abort();
    int bad;
    // Four words: one goes out, three stay queued. Bit 2 of the first word
    // is forced low so the line is low when reset hits mid-DATA.
    s_val[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_dat[0] = 8'($urandom_range(0, 255)) & ((i == 0) ? 8'hFB : 8'hFF);
      @(posedge clk);
      #1;
    end
    s_val[0] = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    tests++;
    if (busy_w[0] !== 1'b1 || cnt_w[0] !== 3'd3 || tx_w[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort setup: busy=%b count=%0d tx=%b, required 1 3 0",
               busy_w[0], cnt_w[0], tx_w[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (tx_w[0] !== 1'b1) begin
      fails++; $display("FAIL abort tx: got %b, required 1", tx_w[0]);
    end
    tests++;
    if (busy_w[0] !== 1'b0) begin
      fails++; $display("FAIL abort busy: got %b, required 0", busy_w[0]);
    end
    tests++;
    if (cnt_w[0] !== 3'd0 || s_rdy[0] !== 1'b1) begin
      fails++; $display("FAIL abort fifo: count=%0d ready=%b, required 0 1", cnt_w[0], s_rdy[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL abort quiet: got %0d active cycles, required 0", bad);
    end
    fill_random(1, 8'hFF);
    run_stream("after_abort", 0, 8, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      s_dat[i] = 8'h00;
      s_val[i] = 1'b0;
    end
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_fifo_full();
    test_seven_bit();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
